// File: rtl/imem_boot_loader.sv
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Streams boot bytes into IMEM as little-endian words, then
//             releases processor reset. Optional macro: IMEM_LOADER_EBREAK_PAD_EN
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
   parameter int IMEM_SIZE_IN_WORDS = 2048,
   parameter int ADDR_WIDTH         = 11,
   parameter int BASE_WORD_ADDR     = 0,
   parameter int RELEASE_DELAY      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  proc_reset,
   output logic                  load_done,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int                  RW       = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
   localparam logic [RW-1:0]       REL_LAST = RW'(RELEASE_DELAY - 1);
   localparam logic [ADDR_WIDTH:0] SIZE_W   = (ADDR_WIDTH + 1)'(IMEM_SIZE_IN_WORDS);
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_WORD_ADDR);
   localparam logic [31:0]         EBREAK   = 32'h0010_0073;

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_FLUSH   = 3'd1,
      S_PAD     = 3'd2,
      S_RELEASE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [1:0]          byte_idx;
   logic [23:0]         asm_lo;
   logic [ADDR_WIDTH:0] widx;
   logic [RW-1:0]       rel_cnt;
   logic                accept;
   logic                issue;
   logic [31:0]         issue_word;

   assign in_ready   = (state == S_LOAD);
   assign accept     = in_valid && in_ready;
   assign proc_reset = (state != S_DONE);
   assign load_done  = (state == S_DONE);
   assign word_count = widx;

   always_ff @(posedge clk) begin
      if (reset) state <= S_LOAD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      issue_word = '0;
      case (state)
         S_LOAD: begin
            if (accept) begin
               // Lanes above the current byte stay zero, which zero-fills a short final word.
               for (int k = 0; k < 3; k++) begin
                  if (k < int'(byte_idx)) issue_word[8*k +: 8] = asm_lo[8*k +: 8];
               end
               issue_word[{byte_idx, 3'b000} +: 8] = in_data;
               issue = in_last || (byte_idx == 2'd3);
               if (in_last) state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
`ifdef IMEM_LOADER_EBREAK_PAD_EN
            state_nxt = S_PAD;
`else
            state_nxt = S_RELEASE;
`endif
         end
         S_PAD: begin
            issue      = 1'b1;
            issue_word = EBREAK;
            state_nxt  = S_RELEASE;
         end
         S_RELEASE: begin
            if (rel_cnt == REL_LAST) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx  <= 2'd0;
         asm_lo    <= '0;
         widx      <= '0;
         rel_cnt   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_A;
         mem_wdata <= '0;
         overflow  <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (accept) begin
            if (issue) begin
               byte_idx <= 2'd0;
            end else begin
               byte_idx <= byte_idx + 2'd1;
               case (byte_idx)
                  2'd0:    asm_lo[7:0]   <= in_data;
                  2'd1:    asm_lo[15:8]  <= in_data;
                  default: asm_lo[23:16] <= in_data;
               endcase
            end
         end
         // widx saturates at the IMEM size, so it doubles as the written-word count.
         if (issue) begin
            if (widx < SIZE_W) begin
               mem_we    <= 1'b1;
               mem_addr  <= BASE_A + widx[ADDR_WIDTH-1:0];
               mem_wdata <= issue_word;
               widx      <= widx + 1'b1;
            end else begin
               overflow  <= 1'b1;
            end
         end
         if (state == S_RELEASE) rel_cnt <= rel_cnt + 1'b1;
         else                    rel_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader (default and tiny IMEM)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];

`ifdef IMEM_LOADER_EBREAK_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif
   localparam int SIZE_A = 2048;
   localparam int RD_A   = 2;
   localparam int SIZE_B = 2;
   localparam int RD_B   = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;

   logic        in_ready_a, mem_we_a, proc_reset_a, load_done_a, overflow_a;
   logic [10:0] mem_addr_a;
   logic [31:0] mem_wdata_a;
   logic [11:0] word_count_a;

   logic        in_ready_b, mem_we_b, proc_reset_b, load_done_b, overflow_b;
   logic [0:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;
   logic [1:0]  word_count_b;

   imem_boot_loader #(
      .IMEM_SIZE_IN_WORDS(SIZE_A), .ADDR_WIDTH(11), .BASE_WORD_ADDR(0), .RELEASE_DELAY(RD_A)
   ) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .proc_reset(proc_reset_a), .load_done(load_done_a), .overflow(overflow_a),
      .word_count(word_count_a)
   );

   imem_boot_loader #(
      .IMEM_SIZE_IN_WORDS(SIZE_B), .ADDR_WIDTH(1), .BASE_WORD_ADDR(0), .RELEASE_DELAY(RD_B)
   ) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .proc_reset(proc_reset_b), .load_done(load_done_b), .overflow(overflow_b),
      .word_count(word_count_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   int unsigned qa_addr[$], qb_addr[$];
   logic [31:0] qa_data[$], qb_data[$];
   int  hs_cyc = -1;
   int  fall_a = -1, fall_b = -1, done_a = -1, done_b = -1;
   bit  prev_pr_a = 1'b1, prev_pr_b = 1'b1, prev_ld_a = 1'b0, prev_ld_b = 1'b0;
   bit  pr_drop = 1'b0;

   // Observe writes, the last handshake and the release edges mid-cycle.
   always @(negedge clk) begin
      if (in_valid && in_ready_a && in_last) hs_cyc = cyc;
      if (mem_we_a) begin qa_addr.push_back(int'(mem_addr_a)); qa_data.push_back(mem_wdata_a); end
      if (mem_we_b) begin qb_addr.push_back(int'(mem_addr_b)); qb_data.push_back(mem_wdata_b); end
      if (prev_pr_a && !proc_reset_a) fall_a = cyc;
      if (prev_pr_b && !proc_reset_b) fall_b = cyc;
      if (!prev_ld_a && load_done_a) done_a = cyc;
      if (!prev_ld_b && load_done_b) done_b = cyc;
      prev_pr_a = proc_reset_a; prev_pr_b = proc_reset_b;
      prev_ld_a = load_done_a;  prev_ld_b = load_done_b;
      if (reset && (!proc_reset_a || !proc_reset_b)) pr_drop = 1'b1;
   end

   function automatic word_q_t model_words(byte_q_t b);
      word_q_t     w;
      logic [31:0] cur;
      int          n = b.size();
      for (int i = 0; i < n; i += 4) begin
         cur = '0;
         for (int j = 0; j < 4; j++)
            if (i + j < n) cur = cur | (32'(b[i+j]) << (8 * j));
         w.push_back(cur);
      end
      if (PAD != 0) w.push_back(32'h0010_0073);
      return w;
   endfunction

   task automatic clear_obs();
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
      hs_cyc = -1; fall_a = -1; fall_b = -1; done_a = -1; done_b = -1;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      clear_obs();
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input bit rnd);
      for (int t = 0; t < 64; t++) begin
         @(posedge clk); #1;
         in_valid = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
         in_data  = b;
         in_last  = last;
         @(negedge clk);
         if (in_valid && in_ready_a) return;
      end
      checks++; errors++;
      $display("FAIL send_byte: byte %02h not accepted, in_ready=%0b required 1", b, in_ready_a);
   endtask

   task automatic test_image(input string name, input byte_q_t b, input bit rnd, input bit do_rst);
      word_q_t     exp;
      int unsigned ga[$];
      logic [31:0] gd[$];
      int          size, rd, exp_n, wc, fall, done;
      bit          ov, ld, pr, rdy;
      if (do_rst) apply_reset();
      exp = model_words(b);
      for (int i = 0; i < b.size(); i++) send_byte(b[i], (i == b.size() - 1), rnd);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      for (int t = 0; t < 60 && !(load_done_a && load_done_b); t++) @(negedge clk);
      checks++;
      if (!(load_done_a && load_done_b)) begin
         errors++;
         $display("FAIL %s timeout: load_done a=%0b b=%0b required 1", name, load_done_a, load_done_b);
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            ga = qa_addr; gd = qa_data; size = SIZE_A; rd = RD_A;
            wc = int'(word_count_a); ov = overflow_a; ld = load_done_a; pr = proc_reset_a;
            rdy = in_ready_a; fall = fall_a; done = done_a;
         end else begin
            ga = qb_addr; gd = qb_data; size = SIZE_B; rd = RD_B;
            wc = int'(word_count_b); ov = overflow_b; ld = load_done_b; pr = proc_reset_b;
            rdy = in_ready_b; fall = fall_b; done = done_b;
         end
         exp_n = (exp.size() < size) ? exp.size() : size;
         checks++;
         if (ga.size() !== exp_n) begin
            errors++;
            $display("FAIL %s[%0d] write_count: got %0d required %0d", name, k, ga.size(), exp_n);
         end
         for (int i = 0; i < exp_n && i < ga.size(); i++) begin
            checks++;
            if (ga[i] !== i || gd[i] !== exp[i]) begin
               errors++;
               $display("FAIL %s[%0d] write%0d: got %08h@%0d required %08h@%0d",
                        name, k, i, gd[i], ga[i], exp[i], i);
            end
         end
         checks++;
         if (wc !== exp_n) begin
            errors++;
            $display("FAIL %s[%0d] word_count: got %0d required %0d", name, k, wc, exp_n);
         end
         checks++;
         if (ov !== (exp.size() > size)) begin
            errors++;
            $display("FAIL %s[%0d] overflow: got %0b required %0b", name, k, ov, exp.size() > size);
         end
         checks++;
         if (ld !== 1'b1 || pr !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d] done_state: got ld=%0b pr=%0b rdy=%0b required 1 0 0",
                     name, k, ld, pr, rdy);
         end
         checks++;
         if (fall - hs_cyc !== 2 + rd + PAD || done !== fall) begin
            errors++;
            $display("FAIL %s[%0d] release_latency: got %0d (done at %0d, fall at %0d) required %0d",
                     name, k, fall - hs_cyc, done, fall, 2 + rd + PAD);
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 11'd0 || mem_wdata_a !== 32'd0 ||
          proc_reset_a !== 1'b1 || load_done_a !== 1'b0 || overflow_a !== 1'b0 || word_count_a !== 12'd0) begin
         errors++;
         $display("FAIL reset_a: got rdy=%0b we=%0b addr=%0d wd=%08h pr=%0b ld=%0b ov=%0b wc=%0d required 1 0 0 0 1 0 0 0",
                  in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, proc_reset_a, load_done_a, overflow_a, word_count_a);
      end
      checks++;
      if (in_ready_b !== 1'b1 || mem_we_b !== 1'b0 || mem_addr_b !== 1'd0 || mem_wdata_b !== 32'd0 ||
          proc_reset_b !== 1'b1 || load_done_b !== 1'b0 || overflow_b !== 1'b0 || word_count_b !== 2'd0) begin
         errors++;
         $display("FAIL reset_b: got rdy=%0b we=%0b addr=%0d wd=%08h pr=%0b ld=%0b ov=%0b wc=%0d required 1 0 0 0 1 0 0 0",
                  in_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, proc_reset_b, load_done_b, overflow_b, word_count_b);
      end
      @(posedge clk); #1;
      clear_obs();
      reset = 1'b0;
   endtask

   task automatic test_spec_images();
      byte_q_t b;
      b = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      test_image("eight_bytes", b, 1'b0, 1'b1);
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      test_image("six_bytes", b, 1'b0, 1'b1);
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      test_image("four_bytes", b, 1'b0, 1'b1);
      b = '{8'h01};
      test_image("one_byte", b, 1'b0, 1'b1);
   endtask

   task automatic test_overflow();
      byte_q_t b;
      b.delete();
      for (int i = 0; i < 12; i++) b.push_back(8'(8'h40 + i));
      test_image("twelve_bytes", b, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      byte_q_t b;
      b.delete();
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      test_image("b2b16", b, 1'b0, 1'b1);
      test_image("gappy16", b, 1'b1, 1'b1);
   endtask

   task automatic test_mid_reset();
      byte_q_t b;
      apply_reset();
      for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), 1'b0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      pr_drop  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_we_a !== 1'b0 || word_count_a !== 12'd0 || in_ready_a !== 1'b1 || proc_reset_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_state: got we=%0b wc=%0d rdy=%0b pr=%0b required 0 0 1 1",
                  mem_we_a, word_count_a, in_ready_a, proc_reset_a);
      end
      @(posedge clk); #1;
      clear_obs();
      reset = 1'b0;
      b = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
      test_image("after_reset", b, 1'b0, 1'b0);
      checks++;
      if (pr_drop !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_proc_reset: got drop=%0b required 0", pr_drop);
      end
   endtask

   task automatic test_random();
      byte_q_t b;
      int      n;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 24);
         b.delete();
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         test_image("random", b, 1'b1, 1'b1);
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_spec_images();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time instruction-memory loader sitting directly upstream of the SoC's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into consecutive IMEM locations while holding the processor in reset. After the final byte it releases the processor reset, which makes simulation bring-up and FPGA boot independent of `$readmemh`.

## Interface
Parameters:
- IMEM_SIZE_IN_WORDS, 2048, IMEM capacity in words; writes beyond it are dropped.
- ADDR_WIDTH, 11, word-address width; must satisfy 2^ADDR_WIDTH >= IMEM_SIZE_IN_WORDS.
- BASE_WORD_ADDR, 0, word address of the first written word.
- RELEASE_DELAY, 2, cycles `proc_reset` stays high after the last IMEM write; minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_last  in  1  marks final byte of image; qualified by in_valid
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  IMEM write strobe, one-cycle pulse
- mem_addr  out  ADDR_WIDTH  IMEM word address
- mem_wdata  out  32  IMEM write data
- proc_reset  out  1  reset to processor; high until load complete
- load_done  out  1  high once processor released
- overflow  out  1  sticky; set if any word addressed at or beyond IMEM_SIZE_IN_WORDS
- word_count  out  ADDR_WIDTH+1  words written so far (includes pad word)

## Operation
- A byte is accepted on a cycle with `in_valid && in_ready`.
- States: LOAD, FLUSH, PAD, RELEASE, DONE. Reset enters LOAD.
- LOAD: `in_ready`=1. Accepted bytes fill the assembly register at lane `byte_idx` (0..3), so byte 0 lands in [7:0]. On the 4th byte, or on any accepted byte with `in_last`, the word is issued to the write stage and `byte_idx` returns to 0.
  - On `in_last` with a partial word, the missing upper lanes are zero-filled.
  - `in_last` goes to FLUSH.
- Write stage is registered. `mem_we`=1 the cycle after the issuing handshake, with `mem_addr` = BASE_WORD_ADDR + word index.
  - Address increments after each write.
  - If the index is >= IMEM_SIZE_IN_WORDS, `mem_we` is suppressed, `overflow` is set and held, and `word_count` does not increment.
- FLUSH: `in_ready`=0. Waits one cycle for the pending write to complete, then goes to PAD if the macro is defined, else to RELEASE.
- PAD: see Configuration.
- RELEASE: counts RELEASE_DELAY cycles with `proc_reset`=1, then goes to DONE.
- DONE: `proc_reset`=0, `load_done`=1, `in_ready`=0. Stays there until `reset`.
- `in_last` on the 4th byte of a word: that full word is written and no extra write occurs.
- `in_last` with a zero-length image cannot occur, since `in_last` always accompanies a byte.
- `reset` mid-load aborts the current word and restarts at BASE_WORD_ADDR. IMEM contents already written are not cleared.

## Timing
- Reset values:
  - `in_ready`=1, `mem_we`=0, `mem_addr`=BASE_WORD_ADDR, `mem_wdata`=0
  - `proc_reset`=1, `load_done`=0, `overflow`=0, `word_count`=0
- Throughput: 1 byte/cycle sustained. A write never stalls `in_ready` in LOAD.
- Latency: 4th-byte handshake at cycle N gives `mem_we` at N+1.
- `in_last` at cycle N with no pad:
  - last write at N+1
  - FLUSH at N+1
  - RELEASE from N+2
  - `proc_reset` falls at N+2+RELEASE_DELAY
- `proc_reset` and `load_done` change in the same cycle.

## Configuration
- `IMEM_LOADER_EBREAK_PAD_EN`
  - Defined: PAD state issues one extra write of 32'h0010_0073 (`ebreak`) at the next word address, then enters RELEASE. The write obeys the overflow rule, and `word_count` includes it. This adds 1 cycle before release.
  - Undefined: FLUSH goes directly to RELEASE and no pad write occurs.

## Test plan
- Stream 8 bytes 13,05,00,00,93,05,10,00 (`in_last` on the 8th), macro off:
  - writes 0x00000513 @0 and 0x00100593 @1
  - `word_count`=2
  - `proc_reset` falls 2 cycles after FLUSH
- Stream 6 bytes AA,BB,CC,DD,11,22 (last on the 6th): writes 0xDDCCBBAA @0 and 0x00002211 @1.
- Macro on, 4 bytes 01,02,03,04 (last):
  - writes 0x04030201 @0 and 0x00100073 @1
  - `word_count`=2
- IMEM_SIZE_IN_WORDS=2, stream 12 bytes:
  - only addresses 0 and 1 written
  - `overflow`=1, `word_count`=2
  - `load_done` still asserted
- `in_valid` toggled randomly over 16 bytes: words identical to the back-to-back case, with `mem_we` exactly 4 pulses.
- `reset` pulsed after 5 bytes, then 4 bytes 0D,0C,0B,0A (last):
  - single write 0x0A0B0C0D @BASE_WORD_ADDR
  - `proc_reset`=1 throughout reset
